// File: rtl/pll_sup_pkg.sv
// Shared types and defaults for the PLL clock supervisor: FSM states,
// counter widths and the nominal frequency-check constants.
package pll_sup_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      MEASURE,
      HOLD,
      RUN,
      FAIL,
      FAULT
   } sup_state_t;

   localparam int CNT_W = 16;
   localparam int TMR_W = 16;
   localparam int RTY_W = 2;

   localparam int DEF_PLL_RST_CYCLES = 16;
   localparam int DEF_LOCK_TIMEOUT   = 50000;
   localparam int DEF_WINDOW         = 1000;
   localparam int DEF_EXP_COUNT      = 200;
   localparam int DEF_TOL            = 4;
   localparam int DEF_HOLD_CYCLES    = 8;
   localparam int DEF_MAX_RETRIES    = 3;

   // One bit wider than the count so the absolute difference cannot wrap.
   function automatic logic in_tol(input logic [CNT_W-1:0] count,
                                   input logic [CNT_W:0]   exp_c,
                                   input logic [CNT_W:0]   tol);
      logic [CNT_W:0] c;
      logic [CNT_W:0] diff;
      c    = {1'b0, count};
      diff = (c >= exp_c) ? (c - exp_c) : (exp_c - c);
      return (diff <= tol);
   endfunction

endpackage

// File: rtl/pll_freq_meter.sv
// Synchronises pll_locked and the outclk toggle into refclk, counts toggle
// edges over fixed windows and flags each window end with its count and verdict.
module pll_freq_meter
   import pll_sup_pkg::*;
#(
   parameter int WINDOW    = DEF_WINDOW,
   parameter int EXP_COUNT = DEF_EXP_COUNT,
   parameter int TOL       = DEF_TOL
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             clk_tgl,
   input  logic             meas_en,
   output logic             locked_s,
   output logic             win_done,
   output logic             win_pass,
   output logic [CNT_W-1:0] win_count
);

   logic             locked_m;
   logic             tgl_m;
   logic             tgl_s;
   logic             tgl_d;
   logic             edge_now;
   logic [CNT_W-1:0] win_tmr;
   logic [CNT_W-1:0] edge_cnt;

   always_ff @(posedge refclk) begin
      if (rst) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
         tgl_m    <= 1'b0;
         tgl_s    <= 1'b0;
         tgl_d    <= 1'b0;
         win_tmr  <= '0;
         edge_cnt <= '0;
      end else begin
         locked_m <= pll_locked;
         locked_s <= locked_m;
         tgl_m    <= clk_tgl;
         tgl_s    <= tgl_m;
         tgl_d    <= tgl_s;
         // Idle or window end: rearm so the next enabled cycle starts a fresh window.
         if (!meas_en || win_done) begin
            win_tmr  <= CNT_W'(WINDOW - 1);
            edge_cnt <= '0;
         end else begin
            win_tmr  <= win_tmr - 1'b1;
            edge_cnt <= win_count;
         end
      end
   end

   assign edge_now  = tgl_s ^ tgl_d;
   assign win_count = (edge_now && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
   assign win_done  = meas_en && (win_tmr == '0);
   assign win_pass  = in_tol(win_count, (CNT_W+1)'(EXP_COUNT), (CNT_W+1)'(TOL));

endmodule

// File: rtl/pll_clk_supervisor.sv
// PLL consumer-side supervisor: sequences PLL reset, waits for lock, verifies
// output frequency and releases sys_rst; retries and latches a fault on repeated failure.
//
// state     | meaning
// PLL_RST   | pll_rst held high for PLL_RST_CYCLES
// WAIT_LOCK | pll_rst low, waiting for locked_s or LOCK_TIMEOUT
// MEASURE   | first frequency window, sys_rst still high
// HOLD      | frequency good, sys_rst held HOLD_CYCLES more
// RUN       | sys_rst low, ready high, windows run back-to-back
// FAIL      | one cycle: count the retry, re-reset PLL or give up
// FAULT     | retries exhausted, terminal until rst
module pll_clk_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
   parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
   parameter int WINDOW         = DEF_WINDOW,
   parameter int EXP_COUNT      = DEF_EXP_COUNT,
   parameter int TOL            = DEF_TOL,
   parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             clk_tgl,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic             fault,
   output logic [CNT_W-1:0] meas_count,
   output logic [RTY_W-1:0] retries
);

   sup_state_t       state;
   logic [TMR_W-1:0] tmr;
   logic             meas_en;
   logic             locked_s;
   logic             win_done;
   logic             win_pass;
   logic [CNT_W-1:0] win_count;
   logic [RTY_W:0]   retries_nxt;

   assign meas_en     = (state == MEASURE) || (state == RUN);
   assign retries_nxt = {1'b0, retries} + 1'b1;

   pll_freq_meter #(
      .WINDOW    (WINDOW),
      .EXP_COUNT (EXP_COUNT),
      .TOL       (TOL)
   ) u_meter (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .clk_tgl    (clk_tgl),
      .meas_en    (meas_en),
      .locked_s   (locked_s),
      .win_done   (win_done),
      .win_pass   (win_pass),
      .win_count  (win_count)
   );

   always_ff @(posedge refclk) begin
      if (rst) begin
         state      <= PLL_RST;
         tmr        <= '0;
         pll_rst    <= 1'b1;
         sys_rst    <= 1'b1;
         ready      <= 1'b0;
         fault      <= 1'b0;
         meas_count <= '0;
         retries    <= '0;
      end else begin
         // A completed window always publishes its count, even when lock loss wins.
         if (win_done)
            meas_count <= win_count;
         case (state)
            PLL_RST: begin
               if (tmr == TMR_W'(PLL_RST_CYCLES - 1)) begin
                  state   <= WAIT_LOCK;
                  pll_rst <= 1'b0;
                  tmr     <= '0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state <= MEASURE;
                  tmr   <= '0;
               end else if (tmr == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  state <= FAIL;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            MEASURE: begin
               if (!locked_s || (win_done && !win_pass)) begin
                  state <= FAIL;
               end else if (win_done) begin
                  state <= HOLD;
                  tmr   <= '0;
               end
            end
            HOLD: begin
               if (!locked_s) begin
                  state <= FAIL;
               end else if (tmr == TMR_W'(HOLD_CYCLES - 1)) begin
                  state   <= RUN;
                  sys_rst <= 1'b0;
                  ready   <= 1'b1;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            RUN: begin
               if (!locked_s || (win_done && !win_pass)) begin
                  state   <= FAIL;
                  sys_rst <= 1'b1;
                  ready   <= 1'b0;
               end
            end
            FAIL: begin
               retries <= retries_nxt[RTY_W] ? '1 : retries_nxt[RTY_W-1:0];
               pll_rst <= 1'b1;
               tmr     <= '0;
               if (retries_nxt == (RTY_W+1)'(MAX_RETRIES)) begin
                  state <= FAULT;
                  fault <= 1'b1;
               end else begin
                  state <= PLL_RST;
               end
            end
            FAULT: begin
               pll_rst <= 1'b1;
               sys_rst <= 1'b1;
               ready   <= 1'b0;
               fault   <= 1'b1;
            end
            default: begin
               state <= PLL_RST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Self-checking bench for pll_clk_supervisor: a behavioural PLL lock model and a
// fractional-rate toggle generator drive the DUT; expectations go through a scoreboard queue.
module tb_pll_clk_supervisor;

   localparam int LOCK_TO = 300;

   logic        refclk = 1'b0;
   logic        rst;
   logic        pll_locked;
   logic        clk_tgl;
   logic        pll_rst;
   logic        sys_rst;
   logic        ready;
   logic        fault;
   logic [15:0] meas_count;
   logic [1:0]  retries;

   int checks = 0;
   int errors = 0;

   // toggle generator: exactly `rate` transitions in any 1000 consecutive cycles
   int rate    = 200;
   bit tgl_run = 1'b1;
   int acc     = 0;

   // PLL lock model
   bit lock_en    = 1'b1;
   bit lock_drop  = 1'b0;
   int lock_delay = 100;
   int lk_cnt     = 0;
   bit lk_model   = 1'b0;

   typedef struct {
      int count;
      bit pass;
   } exp_t;
   exp_t exp_q[$];
   int   rty_q[$];

   pll_clk_supervisor #(
      .LOCK_TIMEOUT (LOCK_TO)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .clk_tgl    (clk_tgl),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .meas_count (meas_count),
      .retries    (retries)
   );

   always #10 refclk = ~refclk;

   always @(negedge refclk) begin
      if (tgl_run) begin
         acc += rate;
         if (acc >= 1000) begin
            acc -= 1000;
            clk_tgl = ~clk_tgl;
         end
      end
      if (pll_rst === 1'b1) begin
         lk_cnt   = 0;
         lk_model = 1'b0;
      end else if (lock_en) begin
         if (lk_cnt >= lock_delay) lk_model = 1'b1;
         else lk_cnt++;
      end
      pll_locked = lk_model && !lock_drop;
   end

   task automatic step();
      @(posedge refclk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(posedge refclk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_ready(input int budget, output int n);
      n = 0;
      while (ready !== 1'b1 && n < budget) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({pll_rst, sys_rst, ready, fault, meas_count, retries} !== {4'b1100, 16'd0, 2'd0}) begin
         errors++;
         $display("FAIL reset_values: got pll_rst=%b sys_rst=%b ready=%b fault=%b meas=%0d retries=%0d want 1 1 0 0 0 0",
                  pll_rst, sys_rst, ready, fault, meas_count, retries);
      end
   endtask

   task automatic test_nominal();
      int   n;
      exp_t e;
      rate = 200;
      exp_q.push_back('{200, 1'b1});
      apply_reset();
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin
         n++;
         step();
      end
      checks++;
      if (n !== 16) begin
         errors++;
         $display("FAIL nominal_pll_rst_width: got %0d want 16", n);
      end
      n = 0;
      while (meas_count === 16'd0 && n < 3000) begin
         n++;
         step();
      end
      e = exp_q.pop_front();
      checks++;
      if (meas_count !== 16'(e.count)) begin
         errors++;
         $display("FAIL nominal_meas_count: got %0d want %0d", meas_count, e.count);
      end
      n = 0;
      while (sys_rst === 1'b1 && n < 100) begin
         n++;
         step();
      end
      checks++;
      if (n !== 8 || ready !== 1'b1) begin
         errors++;
         $display("FAIL nominal_hold: got hold=%0d ready=%b want hold=8 ready=1", n, ready);
      end
   endtask

   task automatic test_tolerance();
      int   rates[4] = '{204, 205, 196, 195};
      bit   oks[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
      int   n;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         rate = rates[i];
         exp_q.push_back('{rates[i], oks[i]});
         apply_reset();
         n = 0;
         while (ready !== 1'b1 && retries === 2'd0 && n < 3000) begin
            n++;
            step();
         end
         e = exp_q.pop_front();
         checks++;
         if (meas_count !== 16'(e.count)) begin
            errors++;
            $display("FAIL tol_count_%0d: got %0d want %0d", rates[i], meas_count, e.count);
         end
         checks++;
         if (ready !== e.pass || retries !== (e.pass ? 2'd0 : 2'd1) || pll_rst !== !e.pass) begin
            errors++;
            $display("FAIL tol_outcome_%0d: got ready=%b retries=%0d pll_rst=%b want ready=%b",
                     rates[i], ready, retries, pll_rst, e.pass);
         end
      end
      rate = 200;
   endtask

   task automatic test_lock_timeout();
      int n;
      int r;
      lock_en = 1'b0;
      for (int k = 1; k <= 3; k++) rty_q.push_back(k);
      apply_reset();
      for (int k = 0; k < 3; k++) begin
         n = 0;
         while (pll_rst === 1'b1 && n < 100) begin
            n++;
            step();
         end
         checks++;
         if (n !== 16) begin
            errors++;
            $display("FAIL timeout_rst_width_%0d: got %0d want 16", k, n);
         end
         n = 0;
         while (pll_rst === 1'b0 && n < 1000) begin
            n++;
            step();
         end
         r = rty_q.pop_front();
         checks++;
         if (n !== LOCK_TO + 1 || retries !== 2'(r)) begin
            errors++;
            $display("FAIL timeout_attempt_%0d: got wait=%0d retries=%0d want wait=%0d retries=%0d",
                     k, n, retries, LOCK_TO + 1, r);
         end
      end
      checks++;
      if ({fault, pll_rst, sys_rst, ready} !== 4'b1110) begin
         errors++;
         $display("FAIL timeout_fault: got fault=%b pll_rst=%b sys_rst=%b ready=%b want 1 1 1 0",
                  fault, pll_rst, sys_rst, ready);
      end
      repeat (500) step();
      checks++;
      if ({fault, pll_rst, sys_rst, ready, retries} !== {4'b1110, 2'd3}) begin
         errors++;
         $display("FAIL fault_sticky: got fault=%b pll_rst=%b retries=%0d want fault=1 pll_rst=1 retries=3",
                  fault, pll_rst, retries);
      end
      apply_reset();
      checks++;
      if (fault !== 1'b0 || retries !== 2'd0) begin
         errors++;
         $display("FAIL fault_cleared: got fault=%b retries=%0d want 0 0", fault, retries);
      end
      lock_en = 1'b1;
   endtask

   task automatic test_lock_loss();
      int   n;
      exp_t e;
      apply_reset();
      wait_ready(3000, n);
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL lockloss_first_ready: got timeout after %0d cycles want ready=1", n);
      end
      lock_drop = 1'b1;
      n = 0;
      while ((ready !== 1'b0 || sys_rst !== 1'b1) && n < 10) begin
         n++;
         step();
      end
      checks++;
      if (n > 4) begin
         errors++;
         $display("FAIL lockloss_latency: got %0d cycles want <= 4", n);
      end
      repeat (50) step();
      lock_drop = 1'b0;
      exp_q.push_back('{200, 1'b1});
      wait_ready(3000, n);
      e = exp_q.pop_front();
      checks++;
      if (ready !== e.pass || meas_count !== 16'(e.count) || retries !== 2'd1) begin
         errors++;
         $display("FAIL lockloss_relock: got ready=%b meas=%0d retries=%0d want 1 %0d 1",
                  ready, meas_count, retries, e.count);
      end
   endtask

   task automatic test_reset_mid_measure();
      int   n;
      exp_t e;
      lock_drop = 1'b1;
      repeat (50) step();
      lock_drop = 1'b0;
      n = 0;
      while (pll_locked !== 1'b1 && n < 1000) begin
         n++;
         step();
      end
      repeat (503) step();
      checks++;
      if (meas_count !== 16'd200 || retries !== 2'd2 || ready !== 1'b0 || sys_rst !== 1'b1) begin
         errors++;
         $display("FAIL midmeas_pre: got meas=%0d retries=%0d ready=%b sys_rst=%b want 200 2 0 1",
                  meas_count, retries, ready, sys_rst);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({pll_rst, sys_rst, ready, fault, meas_count, retries} !== {4'b1100, 16'd0, 2'd0}) begin
         errors++;
         $display("FAIL midmeas_reset: got pll_rst=%b sys_rst=%b ready=%b fault=%b meas=%0d retries=%0d want 1 1 0 0 0 0",
                  pll_rst, sys_rst, ready, fault, meas_count, retries);
      end
      exp_q.push_back('{200, 1'b1});
      wait_ready(3000, n);
      e = exp_q.pop_front();
      checks++;
      if (ready !== e.pass || meas_count !== 16'(e.count) || retries !== 2'd0) begin
         errors++;
         $display("FAIL midmeas_resequence: got ready=%b meas=%0d retries=%0d want 1 %0d 0",
                  ready, meas_count, retries, e.count);
      end
   endtask

   task automatic test_stuck_toggle();
      int   n;
      exp_t e;
      rate    = 200;
      tgl_run = 1'b1;
      apply_reset();
      wait_ready(3000, n);
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL stuck_first_ready: got timeout after %0d cycles want ready=1", n);
      end
      // freeze so the first RUN window still sees all 200 edges and the second sees none
      repeat (998) @(posedge refclk);
      #1;
      tgl_run = 1'b0;
      exp_q.push_back('{0, 1'b0});
      n = 0;
      while (ready === 1'b1 && n < 1100) begin
         n++;
         step();
      end
      e = exp_q.pop_front();
      checks++;
      if (meas_count !== 16'(e.count) || ready !== e.pass || n !== 1002) begin
         errors++;
         $display("FAIL stuck_window: got meas=%0d ready=%b after=%0d want meas=%0d ready=%b after=1002",
                  meas_count, ready, n, e.count, e.pass);
      end
      step();
      checks++;
      if (retries !== 2'd1 || pll_rst !== 1'b1 || sys_rst !== 1'b1) begin
         errors++;
         $display("FAIL stuck_retry: got retries=%0d pll_rst=%b sys_rst=%b want 1 1 1",
                  retries, pll_rst, sys_rst);
      end
      tgl_run = 1'b1;
   endtask

   initial begin
      rst        = 1'b1;
      clk_tgl    = 1'b0;
      pll_locked = 1'b0;
      test_reset();
      test_nominal();
      test_tolerance();
      test_lock_timeout();
      test_lock_loss();
      test_reset_mid_measure();
      test_stuck_toggle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
